// File: rtl/outerprodrc_drain.sv
`default_nettype none
// ============================================================================
// Module      : outerprodrc_drain
// Description : Tile sequencer and result reader for the unary outer-product
//               GEMM array. It clears the array, enables it for a window of
//               CYCLES cycles, snapshots the result matrix, and then streams
//               the result row-major on a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module outerprodrc_drain #(
  parameter  int ROWNUM      = 4,
  parameter  int COLNUM      = 4,
  parameter  int OUTBITWIDTH = 16,
  parameter  int CYCLES      = 256,
  localparam int ROWW        = (ROWNUM > 1) ? $clog2(ROWNUM) : 1,
  localparam int COLW        = (COLNUM > 1) ? $clog2(COLNUM) : 1
) (
  input  logic                                 iClk,
  input  logic                                 iRst,
  input  logic                                 iStart,
  output logic                                 oClr,
  output logic                                 oEn,
  input  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0] iData,
  output logic                                 oValid,
  input  logic                                 iReady,
  output logic [OUTBITWIDTH-1:0]               oData,
  output logic [ROWW-1:0]                      oRow,
  output logic [COLW-1:0]                      oCol,
  output logic                                 oLast,
  output logic                                 oBusy,
  output logic                                 oDone
);

  localparam int              NUM_ELEM = ROWNUM * COLNUM;
  localparam int              DATAW    = NUM_ELEM * OUTBITWIDTH;
  localparam int              CNTW     = $clog2(CYCLES + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(CYCLES - 1);
  localparam logic [ROWW-1:0] LAST_ROW = ROWW'(ROWNUM - 1);
  localparam logic [COLW-1:0] LAST_COL = COLW'(COLNUM - 1);
  localparam logic            SINGLE   = (NUM_ELEM == 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t                 state;
  logic [CNTW-1:0]        win_cnt;
  // Snapshot is kept as a shift register: the element on oData is always
  // the lowest slot, so the next element is simply the next slot up.
  logic [DATAW-1:0]       snapshot;

  logic [OUTBITWIDTH-1:0] next_data;
  logic [ROWW-1:0]        next_row;
  logic [COLW-1:0]        next_col;
  logic                   next_last;

  // Row-major successor of the element currently presented.
  always_comb begin
    next_data = OUTBITWIDTH'(snapshot >> OUTBITWIDTH);
    next_row  = oRow;
    next_col  = oCol + COLW'(1);
    if (oCol == LAST_COL) begin
      next_col = '0;
      next_row = oRow + ROWW'(1);
    end
    next_last = (next_row == LAST_ROW) && (next_col == LAST_COL);
  end

  // Tile sequencer; every output is a register written on state transitions.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      win_cnt  <= '0;
      snapshot <= '0;
      oClr     <= 1'b0;
      oEn      <= 1'b0;
      oValid   <= 1'b0;
      oData    <= '0;
      oRow     <= '0;
      oCol     <= '0;
      oLast    <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            state <= CLEAR;
            oClr  <= 1'b1;
            oBusy <= 1'b1;
          end
        end
        CLEAR: begin
          state   <= RUN;
          win_cnt <= '0;
          oClr    <= 1'b0;
          oEn     <= 1'b1;
        end
        RUN: begin
          if (win_cnt == LAST_CNT) begin
            state <= SETTLE;
            oEn   <= 1'b0;
          end else begin
            win_cnt <= win_cnt + CNTW'(1);
          end
        end
        SETTLE: begin
          // The array output register has caught up with the last enabled
          // cycle, so this is the one edge where iData is taken.
          state    <= DRAIN;
          snapshot <= iData;
          oValid   <= 1'b1;
          oData    <= iData[OUTBITWIDTH-1:0];
          oRow     <= '0;
          oCol     <= '0;
          oLast    <= SINGLE;
        end
        DRAIN: begin
          if (iReady) begin
            if (oLast) begin
              state  <= IDLE;
              oValid <= 1'b0;
              oData  <= '0;
              oRow   <= '0;
              oCol   <= '0;
              oLast  <= 1'b0;
              oBusy  <= 1'b0;
              oDone  <= 1'b1;
            end else begin
              snapshot <= snapshot >> OUTBITWIDTH;
              oData    <= next_data;
              oRow     <= next_row;
              oCol     <= next_col;
              oLast    <= next_last;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_outerprodrc_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_outerprodrc_drain
// Description : Self-checking bench for outerprodrc_drain (2x2x8, 4-cycle
//               window) plus a 1x1, 1-cycle boundary instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outerprodrc_drain;

  localparam int C = 4;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] data = '0;
  logic        oClr, oEn, oValid, oLast, oBusy, oDone;
  logic [7:0]  oData;
  logic        oRow, oCol;

  logic        start1 = 1'b0;
  logic [7:0]  data1 = '0;
  logic        oClr1, oEn1, oValid1, oLast1, oBusy1, oDone1;
  logic [7:0]  oData1;
  logic        oRow1, oCol1;

  int checks = 0;
  int errors = 0;

  outerprodrc_drain #(.ROWNUM(2), .COLNUM(2), .OUTBITWIDTH(8), .CYCLES(4)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .oClr(oClr), .oEn(oEn),
    .iData(data), .oValid(oValid), .iReady(ready), .oData(oData),
    .oRow(oRow), .oCol(oCol), .oLast(oLast), .oBusy(oBusy), .oDone(oDone)
  );

  outerprodrc_drain #(.ROWNUM(1), .COLNUM(1), .OUTBITWIDTH(8), .CYCLES(1)) dut1 (
    .iClk(clk), .iRst(rst), .iStart(start1), .oClr(oClr1), .oEn(oEn1),
    .iData(data1), .oValid(oValid1), .iReady(1'b1), .oData(oData1),
    .oRow(oRow1), .oCol(oCol1), .oLast(oLast1), .oBusy(oBusy1), .oDone(oDone1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard entry: {data, row, col, last}
  typedef struct packed {
    logic [7:0] d;
    logic       r;
    logic       c;
    logic       l;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] data;
    logic [15:0] stall;
    logic        chg;
    logic        start_during;
    int          exp_valid;
    int          exp_done;
  } vec_t;
  vec_t vecs[5];

  int en_cycles = 0;
  int clr_cycles = 0;
  int done_cnt = 0;
  logic       prev_stall = 1'b0;
  logic       prev_rst = 1'b0;
  logic [10:0] prev_out = '0;

  // Monitor: transfers, stalls and array control, sampled on the falling edge.
  always @(negedge clk) begin
    sb_t e;
    if (oEn) en_cycles++;
    if (oClr) clr_cycles++;
    if (oDone) done_cnt++;
    if (oClr && oEn) check("clr_en_overlap", 1, 0);
    if (prev_stall && !prev_rst) begin
      check("stall_hold", {oValid, oData, oRow, oCol, oLast}, {1'b1, prev_out});
    end
    if (oValid && ready) begin
      if (sb_q.size() == 0) begin
        check("sb_extra_transfer", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_element", {oData, oRow, oCol, oLast}, e);
      end
    end
    prev_stall = oValid && !ready;
    prev_rst   = rst;
    prev_out   = {oData, oRow, oCol, oLast};
  end

  task automatic push_tile(input logic [31:0] d);
    for (int e = 0; e < N; e++) begin
      sb_q.push_back({d[e*8 +: 8], 1'(e / 2), 1'(e % 2), (e == N - 1)});
    end
  endtask

  task automatic run_tile(input vec_t v);
    int lat_v;
    int lat_d;
    int k;
    lat_v = -1;
    lat_d = -1;
    k = 0;
    data = v.data;
    ready = 1'b1;
    push_tile(v.data);
    en_cycles = 0;
    clr_cycles = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      start = v.start_during && (oEn || oValid);
      if (oValid && lat_v < 0) lat_v = cyc;
      if (oValid) begin
        ready = !v.stall[k];
        k++;
        if (v.chg) data = 32'hFFFF_FFFF;
      end
      if (oDone) begin
        lat_d = cyc;
        break;
      end
    end
    start = 1'b0;
    ready = 1'b1;
    check("lat_first_valid", lat_v, v.exp_valid);
    check("lat_done", lat_d, v.exp_done);
    repeat (3) @(posedge clk);
    #1;
    check("en_cycles", en_cycles, C);
    check("clr_cycles", clr_cycles, 1);
    check("done_pulses", done_cnt, 1);
    check("idle_after", {oBusy, oValid, oEn}, 0);
    check("sb_empty", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    int lat;
    int dlat;
    int en1;
    vecs[0] = '{32'h4433_2211, 16'h0000, 1'b0, 1'b0, C + 3, C + 3 + N};
    vecs[1] = '{32'h4433_2211, 16'h003E, 1'b0, 1'b0, C + 3, C + 3 + N + 5};
    vecs[2] = '{32'h4433_2211, 16'h0000, 1'b1, 1'b0, C + 3, C + 3 + N};
    vecs[3] = '{32'hA55A_0FF0, 16'h0005, 1'b0, 1'b1, C + 3, C + 3 + N + 2};
    vecs[4] = '{32'h00FF_8001, 16'h002A, 1'b1, 1'b1, C + 3, C + 3 + N + 3};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {oClr, oEn, oValid, oLast, oBusy, oDone, oData, oRow, oCol}, 0);
    check("reset_outs1", {oClr1, oEn1, oValid1, oLast1, oBusy1, oDone1, oData1, oRow1, oCol1}, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_tile(vecs[i]);

    // Reset during the second RUN cycle
    done_cnt = 0;
    data = 32'h4433_2211;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("run2_en", oEn, 1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("rst_run_outs", {oClr, oEn, oValid, oLast, oBusy, oDone, oData, oRow, oCol}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_run_no_done", done_cnt, 0);
    run_tile(vecs[0]);

    // Reset while element 2 is presented
    done_cnt = 0;
    push_tile(32'h4433_2211);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (oValid && oRow && !oCol) break;
      @(posedge clk); #1;
    end
    check("drain_elem2_seen", {oValid, oRow, oCol}, 3'b110);
    ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("rst_drain_outs", {oClr, oEn, oValid, oLast, oBusy, oDone, oData, oRow, oCol}, 0);
    check("rst_drain_pending", sb_q.size(), 2);
    sb_q.delete();
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_drain_no_done", done_cnt, 0);
    run_tile(vecs[1]);

    // Boundary instance: 1x1 matrix, 1-cycle window
    lat = -1;
    dlat = -1;
    en1 = 0;
    data1 = 8'h5C;
    @(posedge clk); #1; start1 = 1'b1;
    for (int cyc = 1; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (oEn1) en1++;
      if (oValid1 && lat < 0) begin
        lat = cyc;
        check("b_elem", {oData1, oRow1, oCol1, oLast1}, {8'h5C, 1'b0, 1'b0, 1'b1});
      end
      if (oDone1) begin
        dlat = cyc;
        break;
      end
    end
    check("b_lat_valid", lat, 4);
    check("b_lat_done", dlat, 5);
    check("b_en_cycles", en1, 1);
    check("b_idle", {oBusy1, oValid1}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
